// File: rtl/lfsr_rng_arbiter.sv
// Two-requester random byte server: an 8-bit Fibonacci LFSR shared between
// requesters via a round-robin arbiter, with seed reload and warm-up sequencing.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready; serves a request or accepts a seed load
// S_SERVE  | grant pulse on the outputs this cycle; clears it next edge
// S_WARMUP | busy; LFSR free-runs WARMUP steps after a seed load
module lfsr_rng_arbiter #(
  parameter int unsigned WARMUP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       seed_load,
  input  logic [7:0] seed_in,
  output logic [1:0] gnt,
  output logic       rnd_valid,
  output logic [7:0] rnd_data,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SERVE  = 2'd1;
  localparam logic [1:0] S_WARMUP = 2'd2;

  localparam logic [7:0] LFSR_INIT  = 8'h8A;
  localparam logic [3:0] WARMUP_CNT = 4'(WARMUP);

  logic [1:0] r_state;
  logic [7:0] r_lfsr;
  logic [3:0] r_cnt;
  logic       r_ptr;
  logic [1:0] r_gnt;
  logic       r_valid;
  logic [7:0] r_data;
  logic       r_busy;

  logic [7:0] w_lfsr_next;
  logic [7:0] w_seed;
  logic       w_win;
  logic [1:0] w_gnt_onehot;

  // x^8 + x^6 + x^5 + x^4 + 1
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // An all-zero seed would lock the LFSR, so it is replaced by the reset value.
  assign w_seed = (seed_in == 8'h00) ? LFSR_INIT : seed_in;

  always_comb begin
    w_win = r_ptr;
    if (req == 2'b01) begin
      w_win = 1'b0;
    end else if (req == 2'b10) begin
      w_win = 1'b1;
    end
  end

  assign w_gnt_onehot = w_win ? 2'b10 : 2'b01;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_INIT;
      r_cnt   <= 4'd0;
      r_ptr   <= 1'b0;
      r_gnt   <= 2'b00;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seed_load) begin
            r_lfsr  <= w_seed;
            r_cnt   <= WARMUP_CNT;
            r_busy  <= 1'b1;
            r_state <= S_WARMUP;
          end else if (req != 2'b00) begin
            r_gnt   <= w_gnt_onehot;
            r_valid <= 1'b1;
            r_data  <= r_lfsr;
            r_lfsr  <= w_lfsr_next;
            r_ptr   <= ~w_win;
            r_state <= S_SERVE;
          end
        end
        S_SERVE: begin
          r_gnt   <= 2'b00;
          r_valid <= 1'b0;
          if (seed_load) begin
            r_lfsr  <= w_seed;
            r_cnt   <= WARMUP_CNT;
            r_busy  <= 1'b1;
            r_state <= S_WARMUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WARMUP: begin
          if (seed_load) begin
            r_lfsr <= w_seed;
            r_cnt  <= WARMUP_CNT;
          end else begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rnd_valid = r_valid;
  assign rnd_data  = r_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Self-checking bench for lfsr_rng_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the serving rules.
module tb_lfsr_rng_arbiter;

  localparam int unsigned WARMUP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [1:0] gnt;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  lfsr_rng_arbiter #(.WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks remaining busy cycles and whether a grant was just issued.
  logic [7:0] m_lfsr;
  int         m_pref;
  int         m_busy_left;
  bit         m_just_granted;
  logic [1:0] m_gnt;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_busy;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = 2'b00;
    seed_load = 1'b0;
    seed_in = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset;
    m_lfsr = 8'h8A;
    m_pref = 0;
    m_busy_left = 0;
    m_just_granted = 0;
    m_gnt = 2'b00;
    m_valid = 1'b0;
    m_data = 8'h00;
    m_busy = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic sl, input logic [7:0] s);
    int winner;
    m_gnt = 2'b00;
    m_valid = 1'b0;
    if (sl) begin
      m_lfsr = (s == 8'h00) ? 8'h8A : s;
      m_busy_left = WARMUP;
      m_just_granted = 0;
    end else if (m_busy_left > 0) begin
      m_lfsr = lfsr_step(m_lfsr);
      m_busy_left--;
    end else if (m_just_granted) begin
      m_just_granted = 0;
    end else if (r != 2'b00) begin
      if (r == 2'b11) winner = m_pref;
      else winner = r[1] ? 1 : 0;
      m_gnt = (winner == 1) ? 2'b10 : 2'b01;
      m_valid = 1'b1;
      m_data = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_pref = 1 - winner;
      m_just_granted = 1;
    end
    m_busy = (m_busy_left > 0);
  endtask

  task automatic test_reset;
    // reset is high from time 0; outputs must be cleared before any clock edge
    #2;
    n_tests++;
    if ({gnt, rnd_valid, rnd_data, busy} !== {2'b00, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: got gnt=%b v=%b d=%h busy=%b, want 00 0 00 0", gnt, rnd_valid, rnd_data, busy);
    end
    do_reset();
    req = 2'b01;
    tick();
    n_tests++;
    if (gnt !== 2'b01 || rnd_data !== 8'h8A) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%b d=%h, want 01 8a", gnt, rnd_data);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({gnt, rnd_valid, rnd_data, busy} !== {2'b00, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got gnt=%b v=%b d=%h busy=%b, want 00 0 00 0", gnt, rnd_valid, rnd_data, busy);
    end
    tick();
    reset = 1'b0;
    req = 2'b00;
  endtask

  task automatic test_single_requester;
    logic [7:0] exp_d [4] = '{8'h8A, 8'h14, 8'h29, 8'h52};
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (gnt !== 2'b01 || rnd_valid !== 1'b1 || rnd_data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: got gnt=%b v=%b d=%h, want 01 1 %h", i, gnt, rnd_valid, rnd_data, exp_d[i]);
      end
      tick();
      n_tests++;
      if (gnt !== 2'b00 || rnd_valid !== 1'b0 || rnd_data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL single_gap[%0d]: got gnt=%b v=%b d=%h, want 00 0 %h", i, gnt, rnd_valid, rnd_data, exp_d[i]);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_both_requesters;
    logic [7:0] exp_d [4] = '{8'h8A, 8'h14, 8'h29, 8'h52};
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (gnt !== exp_g[i] || rnd_valid !== 1'b1 || rnd_data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL both_grant[%0d]: got gnt=%b v=%b d=%h, want %b 1 %h", i, gnt, rnd_valid, rnd_data, exp_g[i], exp_d[i]);
      end
      tick();
      n_tests++;
      if (gnt !== 2'b00) begin
        n_fail++;
        $display("FAIL both_gap[%0d]: got gnt=%b, want 00", i, gnt);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_seed_zero;
    do_reset();
    seed_load = 1'b1;
    seed_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      seed_load = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || gnt !== 2'b00) begin
        n_fail++;
        $display("FAIL seed0_busy[%0d]: got busy=%b gnt=%b, want 1 00", i, busy, gnt);
      end
      req = 2'b01;
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL seed0_release: got busy=%b gnt=%b, want 0 00", busy, gnt);
    end
    tick();
    n_tests++;
    if (gnt !== 2'b01 || rnd_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL seed0_first: got gnt=%b d=%h, want 01 a5", gnt, rnd_data);
    end
    req = 2'b00;
  endtask

  task automatic test_seed_with_req;
    logic [7:0] exp;
    exp = 8'h3C;
    for (int i = 0; i < WARMUP; i++) exp = lfsr_step(exp);
    do_reset();
    req = 2'b01;
    seed_load = 1'b1;
    seed_in = 8'h3C;
    tick();
    seed_load = 1'b0;
    n_tests++;
    if (gnt !== 2'b00 || rnd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seedreq_ignored: got gnt=%b v=%b busy=%b, want 00 0 1", gnt, rnd_valid, busy);
    end
    for (int i = 0; i < 3; i++) tick();
    tick();
    n_tests++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seedreq_release: got gnt=%b busy=%b, want 00 0", gnt, busy);
    end
    tick();
    n_tests++;
    if (gnt !== 2'b01 || rnd_data !== exp) begin
      n_fail++;
      $display("FAIL seedreq_grant: got gnt=%b d=%h, want 01 %h", gnt, rnd_data, exp);
    end
    req = 2'b00;
  endtask

  task automatic test_reload_in_warmup;
    int cycles;
    logic [7:0] exp;
    exp = 8'h55;
    for (int i = 0; i < WARMUP; i++) exp = lfsr_step(exp);
    do_reset();
    seed_load = 1'b1;
    seed_in = 8'h11;
    tick();
    seed_load = 1'b0;
    tick();
    tick();
    seed_load = 1'b1;
    seed_in = 8'h55;
    tick();
    seed_load = 1'b0;
    req = 2'b10;
    cycles = 1;
    while (busy === 1'b1 && cycles < 20) begin
      tick();
      if (busy === 1'b1) cycles++;
    end
    n_tests++;
    if (cycles !== WARMUP) begin
      n_fail++;
      $display("FAIL reload_busy_len: got %0d cycles, want %0d", cycles, WARMUP);
    end
    tick();
    n_tests++;
    if (gnt !== 2'b10 || rnd_data !== exp) begin
      n_fail++;
      $display("FAIL reload_grant: got gnt=%b d=%h, want 10 %h", gnt, rnd_data, exp);
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_warmup;
    do_reset();
    seed_load = 1'b1;
    seed_in = 8'h77;
    tick();
    seed_load = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL midwarm_abort: got busy=%b gnt=%b, want 0 00", busy, gnt);
    end
    tick();
    reset = 1'b0;
    req = 2'b10;
    tick();
    n_tests++;
    if (gnt !== 2'b10 || rnd_data !== 8'h8A) begin
      n_fail++;
      $display("FAIL midwarm_grant: got gnt=%b d=%h, want 10 8a", gnt, rnd_data);
    end
    req = 2'b11;
    tick();
    tick();
    n_tests++;
    if (gnt !== 2'b01 || rnd_data !== 8'h14) begin
      n_fail++;
      $display("FAIL midwarm_pointer: got gnt=%b d=%h, want 01 14", gnt, rnd_data);
    end
    req = 2'b00;
  endtask

  task automatic test_period;
    bit         seen [256];
    logic [7:0] first;
    int         dup_or_zero;
    int         missed;
    dup_or_zero = 0;
    missed = 0;
    first = 8'h00;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (rnd_valid !== 1'b1) missed++;
      if (i == 0) first = rnd_data;
      if (i < 255) begin
        if (rnd_data == 8'h00 || seen[rnd_data]) dup_or_zero++;
        seen[rnd_data] = 1;
      end
      tick();
    end
    n_tests++;
    if (missed !== 0) begin
      n_fail++;
      $display("FAIL period_cadence: got %0d missing grants, want 0", missed);
    end
    n_tests++;
    if (dup_or_zero !== 0) begin
      n_fail++;
      $display("FAIL period_distinct: got %0d repeated/zero values, want 0", dup_or_zero);
    end
    n_tests++;
    if (rnd_data !== first) begin
      n_fail++;
      $display("FAIL period_wrap: got %h, want %h", rnd_data, first);
    end
    req = 2'b00;
  endtask

  task automatic test_random;
    int errs;
    errs = 0;
    do_reset();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      req = 2'($urandom_range(0, 3));
      seed_load = ($urandom_range(0, 15) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      model_step(req, seed_load, seed_in);
      tick();
      n_tests++;
      if (gnt !== m_gnt || rnd_valid !== m_valid || rnd_data !== m_data || busy !== m_busy) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got gnt=%b v=%b d=%h busy=%b, want %b %b %h %b",
                   i, gnt, rnd_valid, rnd_data, busy, m_gnt, m_valid, m_data, m_busy);
      end
    end
    req = 2'b00;
    seed_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_both_requesters();
    test_seed_zero();
    test_seed_with_req();
    test_reload_in_warmup();
    test_reset_mid_warmup();
    test_period();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
LFSR_RNG_ARBITER -- requirements
Module: lfsr_rng_arbiter

Interface
REQ-001 Parameter WARMUP, default 4, meaning number of LFSR steps run after a seed load before requests are served; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  request lines; req[i] high means requester i wants one random byte.
REQ-005 seed_load  input  1  single-cycle strobe to load a new seed.
REQ-006 seed_in  input  8  seed value, sampled when seed_load is high.
REQ-007 gnt  output  2  one-hot grant pulse identifying the requester served this cycle.
REQ-008 rnd_valid  output  1  high for exactly the cycle in which gnt is non-zero.
REQ-009 rnd_data  output  8  random byte delivered with rnd_valid.
REQ-010 busy  output  1  high while seeding/warm-up is in progress; requests are not served while high.

Function
REQ-011 The block SHALL contain one 8-bit Fibonacci LFSR: next = {q[6:0], q[7]^q[5]^q[4]^q[3]} (polynomial x^8+x^6+x^5+x^4+1, period 255).
REQ-012 The LFSR SHALL advance only on a grant cycle or a WARMUP cycle, and SHALL otherwise hold.
REQ-013 The FSM SHALL have three states: IDLE, SERVE, WARMUP.
REQ-014 IDLE, seed_load=1: lfsr <= seed_in (8'h8A if seed_in==0), counter <= WARMUP, busy <= 1, go to WARMUP; pending req is ignored that cycle.
REQ-015 IDLE, seed_load=0, req!=0: gnt <= one-hot winner, rnd_valid <= 1, rnd_data <= current lfsr, lfsr <= next, go to SERVE.
REQ-016 IDLE, seed_load=0, req==0: outputs and LFSR hold, stay in IDLE.
REQ-017 SERVE: gnt <= 0, rnd_valid <= 0, return to IDLE; a grant is therefore a 1-cycle pulse, at most one grant every 2 cycles.
REQ-018 SERVE with seed_load=1: the seed load SHALL take effect exactly as in REQ-014 (gnt/rnd_valid still clear), going to WARMUP.
REQ-019 WARMUP: lfsr <= next and counter decrements each cycle; on the cycle counter==1, busy <= 0 and go to IDLE (busy high for exactly WARMUP cycles).
REQ-020 seed_load during WARMUP SHALL reload the seed (zero guard applied) and restart the counter at WARMUP.
REQ-021 Arbitration: single requester wins unconditionally; when both request, a 1-bit round-robin pointer (0 = requester 0 preferred) selects; the pointer SHALL flip to prefer the other requester after every grant.
REQ-022 rnd_data SHALL hold its last value when rnd_valid is low.
REQ-023 The LFSR SHALL never hold 0 (guaranteed by reset value and seed guard).

Reset
REQ-024 On reset assertion, immediately and regardless of clk: state IDLE, lfsr = 8'h8A, gnt = 2'b00, rnd_valid = 0, rnd_data = 8'h00, busy = 0, counter = 0, round-robin pointer = 0.
REQ-025 Reset asserted during SERVE or WARMUP SHALL abort the operation with no further grant; the first grant after release SHALL deliver 8'h8A.

Verification
REQ-026 Release reset, hold req=2'b01 -> gnt=01 with rnd_data 8'h8A, then 2 cycles later gnt=01 with 8'h14, then 8'h29, 8'h52.
REQ-027 Release reset, hold req=2'b11 -> grants alternate 01,10,01,10 on every second cycle carrying 8'h8A, 8'h14, 8'h29, 8'h52.
REQ-028 seed_load=1, seed_in=8'h00, WARMUP=4 -> busy high exactly 4 cycles, no grant meanwhile; first grant afterwards delivers 8'hA5.
REQ-029 seed_load asserted in the same IDLE cycle as req=2'b01 -> no grant; WARMUP entered; grant issued only after busy falls.
REQ-030 Reset asserted mid-WARMUP and released, req=2'b10 -> gnt=10 with rnd_data 8'h8A; pointer then prefers requester 0.
REQ-031 With req held continuously, 255 consecutive grants -> 255 distinct non-zero rnd_data values, with the 256th equal to the 1st.
